pipe_flow_checker: RTL and testbench

//  Downstream of the cursor/swap datapath. On a start pulse it snapshots the six 18-bit grid rows
//  (6x6 cells of 3-bit pipe codes, cell x at bits [3x+2:3x]) and walks the water path one cell per clock.
//  The path enters cell (0,0) from the LEFT. The game is won if water exits cell (5,5) to the RIGHT.

---
 rtl/pipe_pkg.sv | 54 +++++
 rtl/pipe_flow_checker_if.sv | 39 +++
 rtl/pipe_port_decode.sv | 44 ++++
 rtl/pipe_flow_checker.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_flow_checker.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipe-puzzle datapath.
//   - pipe code constants (PIPE_EMPTY..PIPE_BLOCK), 3 bits per cell
//   - side encoding SIDE_U/R/D/L (2 bits), chosen so that opposite = side ^ 2
//   - grid geometry (GRID_N), walk guard (MAX_STEPS)
//   - checker FSM state type
//   - cell_extract(): pulls the 3-bit code of cell x out of an 18-bit row;
//     the cursor datapath uses the same helper.
package pipe_pkg;

  localparam int GRID_N    = 6;
  localparam int MAX_STEPS = 36;
  localparam int CODE_W    = 3;
  localparam int ROW_W     = GRID_N * CODE_W;

  typedef logic [CODE_W-1:0] pipe_code_t;

  localparam pipe_code_t PIPE_EMPTY = 3'd0;
  localparam pipe_code_t PIPE_LR    = 3'd1;
  localparam pipe_code_t PIPE_UD    = 3'd2;
  localparam pipe_code_t PIPE_LD    = 3'd3;
  localparam pipe_code_t PIPE_UR    = 3'd4;
  localparam pipe_code_t PIPE_LU    = 3'd5;
  localparam pipe_code_t PIPE_DR    = 3'd6;
  localparam pipe_code_t PIPE_BLOCK = 3'd7;

  typedef logic [1:0] side_t;

  localparam side_t SIDE_U = 2'd0;
  localparam side_t SIDE_R = 2'd1;
  localparam side_t SIDE_D = 2'd2;
  localparam side_t SIDE_L = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_FIN,
    ST_DONE
  } flow_state_t;

  // U<->D and R<->L differ only in bit 1 of the encoding.
  function automatic side_t opposite_side(input side_t s);
    return s ^ 2'd2;
  endfunction

  // Cell x of a row lives at bits [3x+2:3x].
  function automatic pipe_code_t cell_extract(input logic [ROW_W-1:0] row,
                                              input logic [2:0] x);
    logic [ROW_W-1:0] shifted;
    shifted = row >> (CODE_W * x);
    return shifted[CODE_W-1:0];
  endfunction

endpackage

// File: rtl/pipe_flow_checker_if.sv
// pipe_flow_checker_if: request/result bundle of the water-flow checker.
//   start      1-cycle walk request
//   r0..r5     grid rows (18 bits, 6 cells x 3-bit code)
//   busy       walk in progress
//   done       1-cycle pulse at the end of a walk
//   win        water left cell (5,5) to the right
//   path_len   cells traversed successfully
//   end_x/y    cell where the walk ended
//   flow_mask  visited cells, bit 6y+x (zero unless FLOW_TRACE_EN)
// master: the requester (drives start/rows); slave: the checker.
interface pipe_flow_checker_if;
  import pipe_pkg::*;

  logic             start;
  logic [ROW_W-1:0] r0;
  logic [ROW_W-1:0] r1;
  logic [ROW_W-1:0] r2;
  logic [ROW_W-1:0] r3;
  logic [ROW_W-1:0] r4;
  logic [ROW_W-1:0] r5;
  logic             busy;
  logic             done;
  logic             win;
  logic [5:0]       path_len;
  logic [2:0]       end_x;
  logic [2:0]       end_y;
  logic [35:0]      flow_mask;

  modport master (
    output start, r0, r1, r2, r3, r4, r5,
    input  busy, done, win, path_len, end_x, end_y, flow_mask
  );

  modport slave (
    input  start, r0, r1, r2, r3, r4, r5,
    output busy, done, win, path_len, end_x, end_y, flow_mask
  );

endinterface

// File: rtl/pipe_port_decode.sv
// pipe_port_decode: combinational port lookup for one cell.
//   code       in  3-bit pipe code
//   entry      in  side the water comes in through
//   ok         out the pipe has a port on the entry side
//   exit_side  out the other port of the pipe (equals entry when !ok)
module pipe_port_decode
  import pipe_pkg::*;
(
  input  pipe_code_t code,
  input  side_t      entry,
  output logic       ok,
  output side_t      exit_side
);

  side_t port_a;
  side_t port_b;
  logic  has_ports;

  always_comb begin
    has_ports = 1'b1;
    port_a    = SIDE_L;
    port_b    = SIDE_R;
    case (code)
      PIPE_LR: begin port_a = SIDE_L; port_b = SIDE_R; end
      PIPE_UD: begin port_a = SIDE_U; port_b = SIDE_D; end
      PIPE_LD: begin port_a = SIDE_L; port_b = SIDE_D; end
      PIPE_UR: begin port_a = SIDE_U; port_b = SIDE_R; end
      PIPE_LU: begin port_a = SIDE_L; port_b = SIDE_U; end
      PIPE_DR: begin port_a = SIDE_D; port_b = SIDE_R; end
      default: has_ports = 1'b0;   // empty and blocked cells
    endcase

    ok        = 1'b0;
    exit_side = entry;
    if (has_ports && entry == port_a) begin
      ok        = 1'b1;
      exit_side = port_b;
    end else if (has_ports && entry == port_b) begin
      ok        = 1'b1;
      exit_side = port_a;
    end
  end

endmodule

// File: rtl/pipe_flow_checker.sv
// pipe_flow_checker: walks the water path through a snapshot of the 6x6
// pipe grid, one cell per clock, and reports win / path length / end cell.
//   clk     in  system clock
//   resetn  in  asynchronous active-low reset (aborts a walk, no done)
//   bus     slave side of pipe_flow_checker_if (start, r0..r5 in;
//           busy, done, win, path_len, end_x, end_y, flow_mask out)
// Water enters (0,0) from the left; the game is won when it leaves (5,5)
// to the right.
// Build option: define FLOW_TRACE_EN to get a visited-cell register on
// flow_mask; otherwise flow_mask is constant zero.
module pipe_flow_checker
  import pipe_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  pipe_flow_checker_if.slave bus
);

  flow_state_t      state_reg;
  logic [ROW_W-1:0] snap_reg [GRID_N];
  logic [2:0]       pos_x_reg;
  logic [2:0]       pos_y_reg;
  side_t            entry_reg;
  logic [5:0]       steps_reg;
  logic             off_pend_reg;   // last good cell exits the grid
  logic             off_win_reg;    // ...and that exit is the winning one
  logic             busy_reg;
  logic             done_reg;
  logic             win_reg;
  logic [5:0]       path_len_reg;
  logic [2:0]       end_x_reg;
  logic [2:0]       end_y_reg;

  logic [ROW_W-1:0] rows_in [GRID_N];
  logic             start_ok;
  pipe_code_t       cur_code;
  logic             cell_ok;
  side_t            exit_side;
  logic             leaves_grid;
  logic [2:0]       next_x;
  logic [2:0]       next_y;
  logic             steps_exhausted;
  logic             cell_taken;

  assign rows_in[0] = bus.r0;
  assign rows_in[1] = bus.r1;
  assign rows_in[2] = bus.r2;
  assign rows_in[3] = bus.r3;
  assign rows_in[4] = bus.r4;
  assign rows_in[5] = bus.r5;

  // A start in FIN is deliberately not accepted; the next one lands in DONE.
  assign start_ok = bus.start && (state_reg == ST_IDLE || state_reg == ST_DONE);

  // Rows are sampled only when a start is accepted; edits during the walk
  // never reach the walker.
  generate
    for (genvar gi = 0; gi < GRID_N; gi++) begin : g_snap
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          snap_reg[gi] <= '0;
        end else if (start_ok) begin
          snap_reg[gi] <= rows_in[gi];
        end
      end
    end
  endgenerate

  assign cur_code = cell_extract(snap_reg[pos_y_reg], pos_x_reg);

  pipe_port_decode u_decode (
    .code      (cur_code),
    .entry     (entry_reg),
    .ok        (cell_ok),
    .exit_side (exit_side)
  );

  // Neighbour in the exit direction. The edge test happens before any
  // arithmetic, so the 3-bit position never wraps.
  always_comb begin
    leaves_grid = 1'b0;
    next_x      = pos_x_reg;
    next_y      = pos_y_reg;
    case (exit_side)
      SIDE_U: if (pos_y_reg == 3'd0) leaves_grid = 1'b1;
              else next_y = pos_y_reg - 3'd1;
      SIDE_D: if (pos_y_reg == 3'(GRID_N - 1)) leaves_grid = 1'b1;
              else next_y = pos_y_reg + 3'd1;
      SIDE_R: if (pos_x_reg == 3'(GRID_N - 1)) leaves_grid = 1'b1;
              else next_x = pos_x_reg + 3'd1;
      SIDE_L: if (pos_x_reg == 3'd0) leaves_grid = 1'b1;
              else next_x = pos_x_reg - 3'd1;
    endcase
  end

  assign steps_exhausted = (steps_reg == 6'(MAX_STEPS));
  assign cell_taken      = (state_reg == ST_STEP) && !off_pend_reg &&
                           !steps_exhausted && cell_ok;

  // Every walk ends with one STEP that adds no cell: either the cell that
  // refuses the water, or the off-grid exit recorded by the previous STEP.
  // That keeps start->done at path_len + 3 cycles for wins and fails alike.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      pos_x_reg    <= '0;
      pos_y_reg    <= '0;
      entry_reg    <= SIDE_L;
      steps_reg    <= '0;
      off_pend_reg <= 1'b0;
      off_win_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      win_reg      <= 1'b0;
      path_len_reg <= '0;
      end_x_reg    <= '0;
      end_y_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            win_reg      <= 1'b0;
            path_len_reg <= '0;
            end_x_reg    <= '0;
            end_y_reg    <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          pos_x_reg    <= '0;
          pos_y_reg    <= '0;
          entry_reg    <= SIDE_L;
          steps_reg    <= '0;
          off_pend_reg <= 1'b0;
          off_win_reg  <= 1'b0;
          state_reg    <= ST_STEP;
        end
        ST_STEP: begin
          if (off_pend_reg) begin
            state_reg <= ST_FIN;
          end else if (cell_taken) begin
            path_len_reg <= path_len_reg + 6'd1;
            steps_reg    <= steps_reg + 6'd1;
            if (leaves_grid) begin
              // Position stays on the last cell so it is reported as the end.
              off_pend_reg <= 1'b1;
              off_win_reg  <= (pos_x_reg == 3'(GRID_N - 1)) &&
                              (pos_y_reg == 3'(GRID_N - 1)) &&
                              (exit_side == SIDE_R);
            end else begin
              pos_x_reg <= next_x;
              pos_y_reg <= next_y;
              entry_reg <= opposite_side(exit_side);
            end
          end else begin
            // Refused cell or walk guard: fail here, off_win_reg stays 0.
            state_reg <= ST_FIN;
          end
        end
        ST_FIN: begin
          end_x_reg <= pos_x_reg;
          end_y_reg <= pos_y_reg;
          win_reg   <= off_win_reg;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.win      = win_reg;
  assign bus.path_len = path_len_reg;
  assign bus.end_x    = end_x_reg;
  assign bus.end_y    = end_y_reg;

`ifdef FLOW_TRACE_EN
  logic [5:0]  cell_idx;
  logic [35:0] mask_reg;

  assign cell_idx = 6'(pos_y_reg) * 6'd6 + 6'(pos_x_reg);

  // Cleared on an accepted start, held after done for the renderer.
  generate
    for (genvar gi = 0; gi < GRID_N * GRID_N; gi++) begin : g_mask
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          mask_reg[gi] <= 1'b0;
        end else if (start_ok) begin
          mask_reg[gi] <= 1'b0;
        end else if (cell_taken && cell_idx == 6'(gi)) begin
          mask_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign bus.flow_mask = mask_reg;
`else
  assign bus.flow_mask = 36'b0;
`endif

endmodule

// File: tb/tb_pipe_flow_checker.sv
// tb_pipe_flow_checker: directed + randomized walks against a vector-based
// reference walk (direction of travel as dx/dy, pipes as pairs of port
// vectors). One line printed per walk.
module tb_pipe_flow_checker;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pipe_flow_checker_if bus ();

  pipe_flow_checker dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] g [6];

  int          m_len;
  int          m_x;
  int          m_y;
  int          m_lat;
  bit          m_win;
  logic [35:0] m_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rows();
    bus.r0 = g[0]; bus.r1 = g[1]; bus.r2 = g[2];
    bus.r3 = g[3]; bus.r4 = g[4]; bus.r5 = g[5];
  endtask

  task automatic clear_grid();
    for (int y = 0; y < 6; y++) g[y] = '0;
  endtask

  task automatic set_cell(input int x, input int y, input int c);
    g[y][3*x +: 3] = 3'(c);
  endtask

  // Scenario 2: down column 0, then right along row 5 -> win.
  task automatic build_win_grid();
    clear_grid();
    set_cell(0, 0, 3);
    for (int y = 1; y < 5; y++) set_cell(0, y, 2);
    set_cell(0, 5, 4);
    for (int x = 1; x < 6; x++) set_cell(x, 5, 1);
  endtask

  // Row serpentine visiting all 36 cells, leaving (0,5) to the left.
  task automatic build_serpentine();
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 6; x++) begin
        if (y % 2 == 0) set_cell(x, y, (x == 5) ? 3 : ((x == 0 && y > 0) ? 4 : 1));
        else            set_cell(x, y, (x == 5) ? 5 : ((x == 0 && y < 5) ? 6 : 1));
      end
  endtask

  // Reference walk over g. Travel direction (dx,dy); a pipe is two port
  // vectors; water enters through the port facing back along travel.
  task automatic model();
    int x, y, dx, dy, ax, ay, bx, by, ex, ey, c;
    bit fin;
    x = 0; y = 0; dx = 1; dy = 0;
    m_len = 0; m_win = 0; m_mask = '0; fin = 0;
    while (!fin) begin
      c = int'(g[y][3*x +: 3]);
      ax = 9; ay = 9; bx = 9; by = 9;
      case (c)
        1: begin ax = -1; ay = 0;  bx = 1;  by = 0; end
        2: begin ax = 0;  ay = -1; bx = 0;  by = 1; end
        3: begin ax = -1; ay = 0;  bx = 0;  by = 1; end
        4: begin ax = 0;  ay = -1; bx = 1;  by = 0; end
        5: begin ax = -1; ay = 0;  bx = 0;  by = -1; end
        6: begin ax = 0;  ay = 1;  bx = 1;  by = 0; end
        default: ;
      endcase
      ex = 0; ey = 0;
      if (m_len >= 36) fin = 1;
      else if (ax == -dx && ay == -dy) begin ex = bx; ey = by; end
      else if (bx == -dx && by == -dy) begin ex = ax; ey = ay; end
      else fin = 1;
      if (!fin) begin
        m_len++;
        m_mask[6*y + x] = 1'b1;
        if (x + ex < 0 || x + ex > 5 || y + ey < 0 || y + ey > 5) begin
          m_win = (x == 5 && y == 5 && ex == 1);
          fin = 1;
        end else begin
          x += ex; y += ey; dx = ex; dy = ey;
        end
      end
    end
    m_x = x; m_y = y; m_lat = m_len + 3;
  endtask

  // poke: cycle after which start is raised for one cycle (-1 none,
  // -2 = so that it is sampled in the FIN cycle). scramble: also rewrite
  // the rows at that moment.
  task automatic run_walk(input string tag, input int poke_in, input bit scramble);
    int cycles, poke;
    bit got;
    logic [35:0] exp_mask;
    model();
    poke = (poke_in == -2) ? m_lat - 1 : poke_in;
    drive_rows();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ".busy_on"}, 64'(bus.busy), 64'd1);
    cycles = 0; got = 0;
    while (!got && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.done === 1'b1) got = 1;
      bus.start = (cycles == poke);
      if (cycles == poke && scramble) begin
        bus.r0 = 18'($urandom); bus.r1 = 18'($urandom); bus.r2 = 18'($urandom);
        bus.r3 = 18'($urandom); bus.r4 = 18'($urandom); bus.r5 = 18'($urandom);
      end
    end
    bus.start = 1'b0;
`ifdef FLOW_TRACE_EN
    exp_mask = m_mask;
`else
    exp_mask = '0;
`endif
    chk({tag, ".latency"},  64'(cycles),       64'(m_lat));
    chk({tag, ".win"},      64'(bus.win),      64'(m_win));
    chk({tag, ".path_len"}, 64'(bus.path_len), 64'(m_len));
    chk({tag, ".end_x"},    64'(bus.end_x),    64'(m_x));
    chk({tag, ".end_y"},    64'(bus.end_y),    64'(m_y));
    chk({tag, ".busy_off"}, 64'(bus.busy),     64'd0);
    chk({tag, ".mask"},     64'(bus.flow_mask), 64'(exp_mask));
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, ".busy_idle"},  64'(bus.busy), 64'd0);
    chk({tag, ".win_hold"},   64'(bus.win),  64'(m_win));
    $display("walk %-12s len=%0d win=%0d end=(%0d,%0d) latency=%0d", tag, m_len, m_win, m_x, m_y, cycles);
  endtask

  initial begin
    int dones;
    bus.start = 1'b0;
    clear_grid();
    drive_rows();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy",     64'(bus.busy),      64'd0);
    chk("reset.done",     64'(bus.done),      64'd0);
    chk("reset.win",      64'(bus.win),       64'd0);
    chk("reset.path_len", 64'(bus.path_len),  64'd0);
    chk("reset.end",      64'({bus.end_x, bus.end_y}), 64'd0);
    chk("reset.mask",     64'(bus.flow_mask), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Power-on grid: (0,0) is U-R, refuses water from the left.
    clear_grid();
    set_cell(0, 0, 4); set_cell(1, 0, 5); set_cell(2, 0, 4);
    set_cell(3, 0, 1); set_cell(4, 0, 5); set_cell(5, 0, 2);
    run_walk("t1_poweron", -1, 0);

    build_win_grid();
    run_walk("t2_win", -1, 0);

    build_win_grid();
    set_cell(3, 5, 2);
    run_walk("t3_break", -1, 0);

    build_win_grid();
    set_cell(5, 5, 5); set_cell(5, 4, 2); set_cell(5, 3, 2); set_cell(5, 2, 6);
    run_walk("t4_upcol", -1, 0);

    build_win_grid();
    run_walk("t5_midstart", 4, 1);

    build_win_grid();
    run_walk("t5_finstart", -2, 0);

    build_serpentine();
    run_walk("t_serp36", -1, 0);

    for (int i = 0; i < 20; i++) begin
      for (int y = 0; y < 6; y++)
        for (int x = 0; x < 6; x++)
          set_cell(x, y, (($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 6)));
      if ($urandom_range(0, 1) == 1) set_cell(0, 0, $urandom_range(1, 3));
      run_walk($sformatf("rnd%0d", i), ($urandom_range(0, 2) == 0) ? 3 : -1, 1);
    end

    // Reset in the middle of a walk: aborts, no done pulse afterwards.
    build_win_grid();
    drive_rows();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_mid.busy",     64'(bus.busy),     64'd0);
    chk("rst_mid.done",     64'(bus.done),     64'd0);
    chk("rst_mid.win",      64'(bus.win),      64'd0);
    chk("rst_mid.path_len", 64'(bus.path_len), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    chk("rst_mid.quiet", 64'(dones), 64'd0);
    $display("walk %-12s reset mid-walk, activity after release=%0d", "t5_reset", dones);

    build_win_grid();
    run_walk("t2_again", -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
